// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Segment type, glyph constants and BCD-to-7-segment lookup.
// Revision : 1.0
// ============================================================================
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_APAGADO = 7'h7F;
    localparam seg_t SEG_GUION   = 7'h7E;

    // Active-low abcdefg; any non-decimal nibble renders as a dash
    function automatic seg_t bcd_a_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    bcd_a_seg = 7'b0000001;
            4'd1:    bcd_a_seg = 7'b1001111;
            4'd2:    bcd_a_seg = 7'b0010010;
            4'd3:    bcd_a_seg = 7'b0000110;
            4'd4:    bcd_a_seg = 7'b1001100;
            4'd5:    bcd_a_seg = 7'b0100100;
            4'd6:    bcd_a_seg = 7'b0100000;
            4'd7:    bcd_a_seg = 7'b0001111;
            4'd8:    bcd_a_seg = 7'b0000000;
            4'd9:    bcd_a_seg = 7'b0000100;
            default: bcd_a_seg = SEG_GUION;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decodificador_bcd_7seg.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_bcd_7seg
// Purpose  : Combinational nibble to active-low 7-segment glyph.
// Revision : 1.0
// ============================================================================
module decodificador_bcd_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = bcd_a_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/display_multiplexado.sv
`default_nettype none
// ============================================================================
// Module   : display_multiplexado
// Purpose  : Scanned common-anode 7-segment driver with leading-zero blanking.
//            Define DISPLAY_PARPADEO_EN to add the blink input.
// Revision : 1.0
// ============================================================================
module display_multiplexado
    import display_pkg::*;
#(
    parameter int NUM_DIGITOS  = 5,
    parameter int SCAN_DIV     = 50000
`ifdef DISPLAY_PARPADEO_EN
    ,
    parameter int PARPADEO_DIV = 25_000_000
`endif
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*NUM_DIGITOS-1:0]   numeroBCD,
    input  logic                       cargar,
    input  logic                       blankCeros,
`ifdef DISPLAY_PARPADEO_EN
    input  logic                       parpadeo,
`endif
    output logic [6:0]                 segmentos,
    output logic [NUM_DIGITOS-1:0]     anodos,
    output logic [((NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1)-1:0] digitoActivo
);

    localparam int IDX_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [4*NUM_DIGITOS-1:0] r_shadow;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;

    logic                     w_fin_scan;
    logic [3:0]               w_nibble;
    logic [NUM_DIGITOS-1:0]   w_anodos;
    logic [NUM_DIGITOS-1:0]   w_visible;
    logic                     w_oculto;
    logic                     w_oscuro;
    seg_t                     w_glifo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (cargar) begin
            r_shadow <= numeroBCD;
        end
    end

    assign w_fin_scan = (r_cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_fin_scan) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_W'(NUM_DIGITOS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A digit is visible if it or any more significant nibble is nonzero;
    // digit 0 is always visible so an all-zero value still shows "0".
    always_comb begin : p_visible
        logic v_seen;
        v_seen    = 1'b0;
        w_visible = '0;
        for (int k = NUM_DIGITOS - 1; k >= 0; k--) begin
            v_seen       = v_seen | (r_shadow[4*k +: 4] != 4'd0) | (k == 0);
            w_visible[k] = v_seen;
        end
    end

    always_comb begin
        w_nibble = 4'd0;
        w_anodos = '1;
        w_oculto = 1'b0;
        for (int k = 0; k < NUM_DIGITOS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_shadow[4*k +: 4];
                w_anodos[k] = 1'b0;
                w_oculto    = blankCeros & ~w_visible[k];
            end
        end
    end

    decodificador_bcd_7seg u_decodificador (
        .i_nibble (w_nibble),
        .o_seg    (w_glifo)
    );

`ifdef DISPLAY_PARPADEO_EN
    localparam int PAR_W = $clog2(PARPADEO_DIV);

    logic [PAR_W-1:0] r_par_cnt;
    logic             r_fase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_cnt <= '0;
            r_fase    <= 1'b0;
        end else if (r_par_cnt == PAR_W'(PARPADEO_DIV - 1)) begin
            r_par_cnt <= '0;
            r_fase    <= ~r_fase;
        end else begin
            r_par_cnt <= r_par_cnt + 1'b1;
        end
    end

    assign w_oscuro = parpadeo & r_fase;
`else
    assign w_oscuro = 1'b0;
`endif

    // Anodes and segments share one register stage so they switch together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segmentos    <= SEG_APAGADO;
            anodos       <= '1;
            digitoActivo <= '0;
        end else begin
            digitoActivo <= r_idx;
            if (w_oscuro) begin
                segmentos <= SEG_APAGADO;
                anodos    <= '1;
            end else begin
                segmentos <= w_oculto ? SEG_APAGADO : w_glifo;
                anodos    <= w_anodos;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_multiplexado.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_multiplexado
// Purpose  : Self-checking bench for display_multiplexado (5 digits, scan 4).
// Revision : 1.0
// ============================================================================
module tb_display_multiplexado;

    localparam int ND = 5;
    localparam int SD = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [19:0] numeroBCD  = '0;
    logic        cargar     = 1'b0;
    logic        blankCeros = 1'b0;
`ifdef DISPLAY_PARPADEO_EN
    logic        parpadeo   = 1'b0;
`endif
    logic [6:0]  segmentos;
    logic [4:0]  anodos;
    logic [2:0]  digitoActivo;

    always #5 clk = ~clk;

    display_multiplexado #(
        .NUM_DIGITOS  (ND),
        .SCAN_DIV     (SD)
`ifdef DISPLAY_PARPADEO_EN
        ,
        .PARPADEO_DIV (8)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .numeroBCD    (numeroBCD),
        .cargar       (cargar),
        .blankCeros   (blankCeros),
`ifdef DISPLAY_PARPADEO_EN
        .parpadeo     (parpadeo),
`endif
        .segmentos    (segmentos),
        .anodos       (anodos),
        .digitoActivo (digitoActivo)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic logic [4:0] onehot_low(input int k);
        onehot_low = ~(5'd1 << k);
    endfunction

    // ---------------- scoreboard: cycle model of the display ----------------
    typedef struct packed {
        logic [6:0] seg;
        logic [4:0] an;
        logic [2:0] idx;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] m_shadow;
    int          m_cnt;
    int          m_idx;

    function automatic exp_t model_out(input logic [19:0] sh, input int idx, input logic bl);
        int   hi;
        exp_t e;
        hi = 0;
        for (int k = 0; k < ND; k++)
            if (sh[4*k +: 4] != 4'd0) hi = k;
        e.idx = idx[2:0];
        e.an  = onehot_low(idx);
        e.seg = (bl && idx > hi) ? 7'h7F : ref_glyph(sh[4*idx +: 4]);
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_shadow <= '0;
            m_cnt    <= 0;
            m_idx    <= 0;
            sb.delete();
        end else begin
            sb.push_back(model_out(m_shadow, m_idx, blankCeros));
            if (cargar) m_shadow <= numeroBCD;
            if (m_cnt == SD - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check_sb(input exp_t e);
        check("sb_seg", {25'd0, segmentos}, {25'd0, e.seg});
        check("sb_an",  {27'd0, anodos},    {27'd0, e.an});
        check("sb_idx", {29'd0, digitoActivo}, {29'd0, e.idx});
    endtask

    always @(negedge clk) begin
        if (!rst && sb.size() > 0) check_sb(sb.pop_front());
    end

    // ---------------- directed helpers ----------------
    task automatic wait_digit(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (digitoActivo == k[2:0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_not_digit(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (digitoActivo != k[2:0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load(input logic [19:0] v, input logic bl);
        @(negedge clk);
        numeroBCD  = v;
        blankCeros = bl;
        cargar     = 1'b1;
        @(negedge clk);
        cargar     = 1'b0;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [19:0]     bcd;
        logic            bl;
        logic [4:0][6:0] seg;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;

        vecs[0] = {20'h01234, 1'b1, 7'h7F, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        vecs[1] = {20'h00000, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0000001};
        vecs[2] = {20'h0A009, 1'b1, 7'h7F, 7'b1111110, 7'b0000001, 7'b0000001, 7'b0000100};
        vecs[3] = {20'h56789, 1'b0, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        vecs[4] = {20'h00000, 1'b0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
        vecs[5] = {20'h0F0B0, 1'b1, 7'h7F, 7'b1111110, 7'b0000001, 7'b1111110, 7'b0000001};

        // Reset state and scan cadence from release
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, segmentos}, 32'h7F);
        check("rst_an",  {27'd0, anodos},    32'h1F);
        check("rst_idx", {29'd0, digitoActivo}, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("first_seg", {25'd0, segmentos}, 32'b0000001);
                check("first_an",  {27'd0, anodos},    32'b11110);
            end
            check($sformatf("cadence_c%0d", c), {29'd0, digitoActivo}, (c / SD) % ND);
        end

        // Table-driven glyph / blanking vectors
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].bcd, vecs[v].bl);
            for (int k = 0; k < ND; k++) begin
                wait_digit(k, ok);
                check($sformatf("v%0d_wait_d%0d", v, k), {31'd0, ok}, 32'd1);
                check($sformatf("v%0d_d%0d_seg", v, k), {25'd0, segmentos}, {25'd0, vecs[v].seg[k]});
                check($sformatf("v%0d_d%0d_an", v, k),  {27'd0, anodos}, {27'd0, onehot_low(k)});
            end
        end

        // Load coinciding with the 4 -> 0 wrap
        load(20'h00000, 1'b0);
        wait_not_digit(4, ok);
        check("wrap_wait_a", {31'd0, ok}, 32'd1);
        wait_digit(4, ok);
        check("wrap_wait_b", {31'd0, ok}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        numeroBCD = 20'h99999;
        cargar    = 1'b1;
        @(negedge clk);
        cargar    = 1'b0;
        check("wrap_last_idx4", {29'd0, digitoActivo}, 32'd4);
        @(negedge clk);
        check("wrap_idx0", {29'd0, digitoActivo}, 32'd0);
        check("wrap_seg9", {25'd0, segmentos}, 32'b0000100);
        check("wrap_an",   {27'd0, anodos},    32'b11110);

        // Asynchronous reset in the middle of the scan
        wait_digit(2, ok);
        check("arst_wait", {31'd0, ok}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_seg", {25'd0, segmentos}, 32'h7F);
        check("arst_an",  {27'd0, anodos},    32'h1F);
        check("arst_idx", {29'd0, digitoActivo}, 32'd0);
        repeat (2) @(negedge clk);
        check("arst_hold_an", {27'd0, anodos}, 32'h1F);
        rst = 1'b0;
        @(negedge clk);
        check("arst_rel_seg", {25'd0, segmentos}, 32'b0000001);
        check("arst_rel_an",  {27'd0, anodos},    32'b11110);
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_multiplexado.md
Name: display_multiplexado

Overview:
- Time-multiplexed driver for a common-anode 7-segment bank of NUM_DIGITOS digits.
- Latches a packed BCD word on a load strobe and scans one digit at a time.
- Each output digit has a proper "0" glyph, optional leading-zero blanking, and a dash for invalid nibbles.
- Sits between the binary-to-BCD converter and the board pins. It replaces per-digit static decoding and cuts pin count to 7 + NUM_DIGITOS.

Parameters:
- NUM_DIGITOS, 5, number of BCD digits and anode lines (range 1..8).
- SCAN_DIV, 50000, clock cycles each digit stays lit (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- numeroBCD  in  4*NUM_DIGITOS  packed BCD; nibble k (bits 4k+3:4k) is digit k, and digit 0 is least significant.
- cargar  in  1  load strobe: copies numeroBCD into the shadow register.
- blankCeros  in  1  1 = blank leading zeros.
- segmentos  out  7  active-low segments, bit6=a down to bit0=g.
- anodos  out  NUM_DIGITOS  active-low digit enables, one-hot-low.
- digitoActivo  out  $clog2(NUM_DIGITOS) (min 1)  index of the digit being driven.

Behaviour:
- Reset, asynchronous on rst high:
  - shadow = 0, scan counter = 0, idx = 0.
  - segmentos = 7'b1111111, anodos = all 1s, digitoActivo = 0.
- Shadow register:
  - When cargar = 1 at a clock edge, shadow <= numeroBCD.
  - Otherwise the shadow holds. Display changes never tear mid-digit beyond one cycle.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and idx advances; idx wraps from NUM_DIGITOS-1 to 0.
- Output registers are updated every cycle from the current idx and shadow (latency 1):
  - anodos = ~(1 << idx).
  - segmentos = glyph of nibble idx.
  - digitoActivo = idx.
  - anodos and segmentos always change on the same edge, so there is no ghost glyph.
- Glyphs, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - nibbles A-F: dash 1111110.
- Leading-zero blanking, when blankCeros = 1:
  - Every digit k above the highest nonzero nibble of the shadow outputs 1111111; its anode is still asserted.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - An invalid nibble counts as nonzero.
- Simultaneous events: cargar coinciding with idx advance is legal. The new shadow is used from the following cycle's output update.
- Reset mid-scan forces all outputs off immediately. The first cycle after release drives digit 0 from shadow = 0, i.e. "0".
- After release, each digit stays lit for exactly SCAN_DIV cycles.

Optional Feature:
- Macro DISPLAY_PARPADEO_EN.
- When defined:
  - Adds input parpadeo (1 bit) and parameter PARPADEO_DIV (default 25_000_000).
  - A free-running blink counter toggles a phase bit every PARPADEO_DIV cycles; counter and phase reset to 0.
  - While parpadeo = 1 and phase = 1, anodos are all 1s and segmentos = 1111111. Scan continues underneath.
- When undefined: no extra port or counter; the display is always lit.

Decomposition:
- Package display_pkg:
  - segment typedef seg_t (logic [6:0]).
  - constants SEG_APAGADO = 7'h7F and SEG_GUION = 7'h7E.
  - glyph lookup function bcd_a_seg(nibble) returning seg_t.
- Sub-module decodificador_bcd_7seg: purely combinational nibble to seg_t, instantiated once on the muxed nibble.

Test Plan (NUM_DIGITOS=5, SCAN_DIV=4):
- Reset release, cargar never asserted, blankCeros=0:
  - first output cycle: anodos=11110, segmentos=0000001.
  - idx advances every 4 cycles: 0,1,2,3,4,0.
- Load 20'h01234, blankCeros=1:
  - digits 0..3 show 4,3,2,1 glyphs.
  - digit 4 shows 1111111 with anodos=01111.
- Load 20'h00000, blankCeros=1: only digit 0 shows 0000001; digits 1..4 show 1111111.
- Load 20'h0A009, blankCeros=1:
  - digit 3 shows 1111110 (dash).
  - digits 1,2 show 0000001.
  - digit 4 is blank.
- Assert cargar with 20'h99999 on the cycle idx wraps 4->0: the next output is digit 0 = 0000100.
- Assert rst mid-scan at idx=2: outputs go all-off asynchronously. With DISPLAY_PARPADEO_EN, parpadeo=1 and PARPADEO_DIV=8: the display is dark for 8 cycles, then lit for 8.
